// File: rtl/beam_delay_controller_pkg.sv
// Shared sizing and FSM encoding for the beam delay controller slice.
// Holds no logic, so it adds no latency and applies no backpressure.
package beam_delay_controller_pkg;

  localparam int NUM_CHANNELS = 3;
  localparam int BUFFER_SIZE  = 16;
  localparam int IDX_W        = $clog2(BUFFER_SIZE) + 1;
  localparam int SEL_W        = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } bdc_state_t;

endpackage

// File: rtl/beam_delay_controller_if.sv
// Pin-side config signals and the steering outputs of the beam delay controller.
// Wiring only: no latency, and the serial pins have no backpressure path.
interface beam_delay_controller_if
  import beam_delay_controller_pkg::*;
();

  logic                          cfg_sclk;
  logic                          cfg_sdata;
  logic                          cfg_latch;
  logic [SEL_W-1:0]              cfg_sel;
  logic                          cfg_err_clr;
  logic                          frame_strobe;
  logic [NUM_CHANNELS*IDX_W-1:0] read_index_flat;
  logic                          delay_update;
  logic                          commit_pending;
  logic                          cfg_err;

  modport master (
    output cfg_sclk, cfg_sdata, cfg_latch, cfg_sel, cfg_err_clr, frame_strobe,
    input  read_index_flat, delay_update, commit_pending, cfg_err
  );

  modport slave (
    input  cfg_sclk, cfg_sdata, cfg_latch, cfg_sel, cfg_err_clr, frame_strobe,
    output read_index_flat, delay_update, commit_pending, cfg_err
  );

endinterface

// File: rtl/beam_delay_controller_cfg_edge_sync.sv
// Two-flop synchronizer plus rising-edge detect for a slow asynchronous pin.
// rise is valid two clk edges after the pin is first sampled high; no backpressure.
module cfg_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic sync1, sync2, sync3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise = sync2 & ~sync3;

endmodule

// File: rtl/beam_delay_controller.sv
// Serial delay-word loader with shadow registers committed atomically on frame_strobe.
// Pin events act 3 clk edges after sampling; commit lands on the strobe edge; no backpressure.
module beam_delay_controller
  import beam_delay_controller_pkg::*;
(
  input logic                    clk,
  input logic                    rst_n,
  beam_delay_controller_if.slave bus
);

  localparam int               CNT_W    = $clog2(IDX_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(IDX_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(IDX_W + 1);
  localparam logic [SEL_W-1:0] SEL_LIM  = SEL_W'(NUM_CHANNELS);
  localparam logic [IDX_W-1:0] IDX_LIM  = IDX_W'(BUFFER_SIZE);

  logic                          sclk_evt;
  logic                          latch_evt;
  logic                          sdata_s1, sdata_s2;
  logic [IDX_W-1:0]              shift_reg, shift_nxt;
  logic [CNT_W-1:0]              bit_cnt, cnt_nxt;
  logic [IDX_W-1:0]              shadow [NUM_CHANNELS];
  logic [IDX_W-1:0]              active [NUM_CHANNELS];
  logic [NUM_CHANNELS*IDX_W-1:0] flat;
  bdc_state_t                    state;
  logic                          pending_q;
  logic                          update_q;
  logic                          err_q;
  logic                          word_ok;
  logic                          word_bad;

  cfg_edge_sync u_sclk_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (bus.cfg_sclk),
    .rise (sclk_evt)
  );

  cfg_edge_sync u_latch_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (bus.cfg_latch),
    .rise (latch_evt)
  );

  // Data rides the same two-flop delay so it lines up with the sclk event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdata_s1 <= 1'b0;
      sdata_s2 <= 1'b0;
    end else begin
      sdata_s1 <= bus.cfg_sdata;
      sdata_s2 <= sdata_s1;
    end
  end

  // A latch in the same cycle as a shift judges the post-shift word.
  always_comb begin
    shift_nxt = shift_reg;
    cnt_nxt   = bit_cnt;
    if (sclk_evt) begin
      shift_nxt = {shift_reg[IDX_W-2:0], sdata_s2};
      if (bit_cnt != CNT_SAT) cnt_nxt = bit_cnt + 1'b1;
    end
  end

  assign word_ok  = latch_evt && (cnt_nxt == CNT_FULL) &&
                    (bus.cfg_sel < SEL_LIM) && (shift_nxt < IDX_LIM);
  assign word_bad = latch_evt && !word_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      state     <= IDLE;
      pending_q <= 1'b0;
      update_q  <= 1'b0;
      err_q     <= 1'b0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        shadow[c] <= '0;
        active[c] <= '0;
      end
    end else begin
      shift_reg <= shift_nxt;
      bit_cnt   <= latch_evt ? '0 : cnt_nxt;
      update_q  <= 1'b0;

      if (word_bad)             err_q <= 1'b1;
      else if (bus.cfg_err_clr) err_q <= 1'b0;

      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (word_ok && (bus.cfg_sel == SEL_W'(c))) shadow[c] <= shift_nxt;
      end

      case (state)
        IDLE: begin
          if (word_ok) begin
            state     <= PENDING;
            pending_q <= 1'b1;
          end
        end
        PENDING: begin
          // Commit takes the pre-write shadow; a coincident write stays pending.
          if (bus.frame_strobe) begin
            for (int c = 0; c < NUM_CHANNELS; c++) active[c] <= shadow[c];
            update_q <= 1'b1;
            if (!word_ok) begin
              state     <= IDLE;
              pending_q <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    flat = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) flat[c*IDX_W +: IDX_W] = active[c];
  end

  assign bus.read_index_flat = flat;
  assign bus.delay_update    = update_q;
  assign bus.commit_pending  = pending_q;
  assign bus.cfg_err         = err_q;

endmodule

// File: tb/tb_beam_delay_controller.sv
// Directed bench for beam_delay_controller: serial loads, validation, atomic commit, reset.
module tb_beam_delay_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  beam_delay_controller_if bus ();

  beam_delay_controller dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic shift_bit(input logic b);
    bus.cfg_sdata = b;
    bus.cfg_sclk  = 1'b1;
    tick(3);
    bus.cfg_sclk  = 1'b0;
    tick(3);
  endtask

  task automatic shift_word(input logic [4:0] w, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) shift_bit(w[i]);
  endtask

  task automatic latch(input logic [2:0] sel);
    bus.cfg_sel   = sel;
    bus.cfg_latch = 1'b1;
    tick(3);
    bus.cfg_latch = 1'b0;
    tick(3);
  endtask

  task automatic strobe();
    bus.frame_strobe = 1'b1;
    tick(1);
    bus.frame_strobe = 1'b0;
  endtask

  task automatic clear_err();
    bus.cfg_err_clr = 1'b1;
    tick(1);
    bus.cfg_err_clr = 1'b0;
  endtask

  initial begin
    bus.cfg_sclk     = 1'b0;
    bus.cfg_sdata    = 1'b0;
    bus.cfg_latch    = 1'b0;
    bus.cfg_sel      = 3'd0;
    bus.cfg_err_clr  = 1'b0;
    bus.frame_strobe = 1'b0;

    // 1: reset state
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check("rst_flat", 32'(bus.read_index_flat), 32'd0);
    check("rst_update", 32'(bus.delay_update), 32'd0);
    check("rst_pending", 32'(bus.commit_pending), 32'd0);
    check("rst_err", 32'(bus.cfg_err), 32'd0);

    // 2: ch1 = 7, committed on the strobe
    shift_word(5'b00111, 5);
    check("t2_pend_before_latch", 32'(bus.commit_pending), 32'd0);
    latch(3'd1);
    check("t2_pending", 32'(bus.commit_pending), 32'd1);
    check("t2_flat_before", 32'(bus.read_index_flat), 32'd0);
    strobe();
    check("t2_flat", 32'(bus.read_index_flat), 32'd224);
    check("t2_update", 32'(bus.delay_update), 32'd1);
    check("t2_pend_after", 32'(bus.commit_pending), 32'd0);
    tick(1);
    check("t2_update_one_cycle", 32'(bus.delay_update), 32'd0);

    // 3: out-of-range value 16
    shift_word(5'b10000, 5);
    latch(3'd0);
    check("t3_err", 32'(bus.cfg_err), 32'd1);
    check("t3_no_pending", 32'(bus.commit_pending), 32'd0);
    strobe();
    check("t3_idle_strobe_update", 32'(bus.delay_update), 32'd0);
    check("t3_idle_strobe_flat", 32'(bus.read_index_flat), 32'd224);
    clear_err();
    check("t3_err_cleared", 32'(bus.cfg_err), 32'd0);

    // 4a: short word, then a full word proves the counter restarted
    shift_word(5'b00011, 4);
    latch(3'd2);
    check("t4_short_err", 32'(bus.cfg_err), 32'd1);
    check("t4_short_no_pending", 32'(bus.commit_pending), 32'd0);
    clear_err();
    shift_word(5'b00001, 5);
    latch(3'd0);
    check("t4_cnt_reset_pending", 32'(bus.commit_pending), 32'd1);
    check("t4_cnt_reset_err", 32'(bus.cfg_err), 32'd0);

    // 4b: bad channel select, with a clear landing on the same edge
    shift_word(5'b00010, 5);
    bus.cfg_sel   = 3'd3;
    bus.cfg_latch = 1'b1;
    tick(2);
    bus.cfg_err_clr = 1'b1;
    tick(1);
    bus.cfg_err_clr = 1'b0;
    check("t4_badsel_err_set_wins", 32'(bus.cfg_err), 32'd1);
    bus.cfg_latch = 1'b0;
    tick(3);
    check("t4_badsel_flat", 32'(bus.read_index_flat), 32'd224);
    clear_err();
    check("t4_err_cleared", 32'(bus.cfg_err), 32'd0);

    // 5: ch0=3 staged; strobe coincides with latch of ch2=9
    shift_word(5'b00011, 5);
    latch(3'd0);
    shift_word(5'b01001, 5);
    bus.cfg_sel   = 3'd2;
    bus.cfg_latch = 1'b1;
    tick(2);
    strobe();
    check("t5_flat_first", 32'(bus.read_index_flat), 32'd227);
    check("t5_update_first", 32'(bus.delay_update), 32'd1);
    check("t5_still_pending", 32'(bus.commit_pending), 32'd1);
    bus.cfg_latch = 1'b0;
    tick(3);
    strobe();
    check("t5_flat_second", 32'(bus.read_index_flat), 32'd9443);
    check("t5_pend_after", 32'(bus.commit_pending), 32'd0);

    // 6: reset mid-word while pending
    shift_word(5'b00110, 5);
    latch(3'd1);
    check("t6_pending", 32'(bus.commit_pending), 32'd1);
    shift_word(5'b10101, 3);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_flat", 32'(bus.read_index_flat), 32'd0);
    check("t6_async_pending", 32'(bus.commit_pending), 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    strobe();
    check("t6_lost_commit_update", 32'(bus.delay_update), 32'd0);
    check("t6_lost_commit_flat", 32'(bus.read_index_flat), 32'd0);
    shift_word(5'b01100, 5);
    latch(3'd0);
    check("t6_new_pending", 32'(bus.commit_pending), 32'd1);
    strobe();
    check("t6_new_flat", 32'(bus.read_index_flat), 32'd12);
    check("t6_new_update", 32'(bus.delay_update), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
